// File: rtl/rv_pkg.sv
// Shared decode-stage definitions for the load/store-multiple sequencer.
// Holds the opcodes, sequencer state encoding and register-index widths.
package rv_pkg;

    localparam int REG_IDX_W = 3;
    localparam int MASK_W    = 8;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_t;

endpackage

// File: rtl/lm_sm_sequencer_lsb_priority_encoder.sv
// Lowest-set-bit finder for the 8-bit register mask: index, one-hot of that bit
// (used to clear it) and a flag for "exactly one bit set".
import rv_pkg::*;

module lsb_priority_encoder (
    input  logic [MASK_W-1:0]    mask,
    output logic [REG_IDX_W-1:0] index,
    output logic [MASK_W-1:0]    onehot,
    output logic                 single
);

    // below[i] is set when any bit under position i is set
    logic [MASK_W:0] below;

    assign below[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < MASK_W; gi++) begin : g_scan
            assign below[gi+1] = below[gi] | mask[gi];
            assign onehot[gi]  = mask[gi] & ~below[gi];
        end
    endgenerate

    always_comb begin
        index = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (onehot[i]) begin
                index = index | REG_IDX_W'(i);
            end
        end
    end

    assign single = (mask != '0) && ((mask & ~onehot) == '0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// Decode-stage sequencer that expands LM/SM into one load/store micro-op per
// set mask bit (R0 first), freezing decode until the final micro-op issues.
import rv_pkg::*;

module lm_sm_sequencer #(
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [3:0]           op_in,
    input  logic [MASK_W-1:0]    imm8_in,
    input  logic [REG_IDX_W-1:0] base_in,
    input  logic                 stall_in,
    input  logic                 flush_in,
    output logic                 hold_decode,
    output logic                 uop_valid,
    output logic                 uop_is_load,
    output logic [REG_IDX_W-1:0] uop_reg,
    output logic [REG_IDX_W-1:0] uop_base,
    output logic [DATA_W-1:0]    uop_offset,
    output logic                 uop_last
);

    seq_state_t           state_q, state_next;
    logic [MASK_W-1:0]    mask_q, mask_next;
    logic                 is_load_q, is_load_next;
    logic [REG_IDX_W-1:0] base_q, base_next;
    logic [REG_IDX_W-1:0] cnt_q, cnt_next;

    logic [REG_IDX_W-1:0] low_idx;
    logic [MASK_W-1:0]    low_onehot;
    logic                 low_single;
    logic                 accept;
    logic                 live;

    lsb_priority_encoder u_pe (
        .mask   (mask_q),
        .index  (low_idx),
        .onehot (low_onehot),
        .single (low_single)
    );

    // An empty mask is never accepted, so it falls through decode as a no-op
    assign accept = valid_in & ~flush_in
                  & ((op_in == OP_LM) | (op_in == OP_SM))
                  & (imm8_in != '0);

    always_comb begin
        state_next   = state_q;
        mask_next    = mask_q;
        is_load_next = is_load_q;
        base_next    = base_q;
        cnt_next     = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_next   = ISSUE;
                    mask_next    = imm8_in;
                    is_load_next = (op_in == OP_LM);
                    base_next    = base_in;
                    cnt_next     = '0;
                end
            end
            ISSUE: begin
                if (!stall_in) begin
                    mask_next = mask_q & ~low_onehot;
                    cnt_next  = cnt_q + 1'b1;
                    if (low_single) begin
                        state_next = IDLE;
                        mask_next  = '0;
                        cnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Flush overrides both accept and stall
        if (flush_in) begin
            state_next = IDLE;
            mask_next  = '0;
            cnt_next   = '0;
        end
    end

    always_comb begin
        live        = (state_q == ISSUE) & ~rst;
        uop_valid   = live & ~flush_in;
        uop_is_load = live & is_load_q;
        uop_reg     = live ? low_idx : '0;
        uop_base    = live ? base_q : '0;
        uop_offset  = live ? DATA_W'(cnt_q) : '0;
        uop_last    = live & low_single;

        hold_decode = 1'b0;
        if (!rst && !flush_in) begin
            if (state_q == IDLE) begin
                hold_decode = accept;
            end else begin
                // Release one cycle early so the next instruction arrives without a bubble
                hold_decode = ~(low_single & ~stall_in);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            is_load_q <= 1'b0;
            base_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_next;
            mask_q    <= mask_next;
            is_load_q <= is_load_next;
            base_q    <= base_next;
            cnt_q     <= cnt_next;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer: LM/SM expansion, stall, flush, reset,
// empty mask and back-to-back sequences, one line per checked cycle.
module tb_lm_sm_sequencer;

    localparam int DATA_W = 16;
    localparam logic [3:0] LM = 4'b0110;
    localparam logic [3:0] SM = 4'b0111;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic [3:0]        op_in;
    logic [7:0]        imm8_in;
    logic [2:0]        base_in;
    logic              stall_in;
    logic              flush_in;
    logic              hold_decode;
    logic              uop_valid;
    logic              uop_is_load;
    logic [2:0]        uop_reg;
    logic [2:0]        uop_base;
    logic [DATA_W-1:0] uop_offset;
    logic              uop_last;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    lm_sm_sequencer #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .op_in       (op_in),
        .imm8_in     (imm8_in),
        .base_in     (base_in),
        .stall_in    (stall_in),
        .flush_in    (flush_in),
        .hold_decode (hold_decode),
        .uop_valid   (uop_valid),
        .uop_is_load (uop_is_load),
        .uop_reg     (uop_reg),
        .uop_base    (uop_base),
        .uop_offset  (uop_offset),
        .uop_last    (uop_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every output against one expected micro-op (or idle) vector
    task automatic expect_out(input string tag, input logic v, input logic ld,
                              input logic [2:0] r, input logic [2:0] b,
                              input logic [DATA_W-1:0] off, input logic last,
                              input logic hold);
        chk({tag, ".valid"}, 32'(uop_valid), 32'(v));
        chk({tag, ".is_load"}, 32'(uop_is_load), 32'(ld));
        chk({tag, ".reg"}, 32'(uop_reg), 32'(r));
        chk({tag, ".base"}, 32'(uop_base), 32'(b));
        chk({tag, ".offset"}, 32'(uop_offset), 32'(off));
        chk({tag, ".last"}, 32'(uop_last), 32'(last));
        chk({tag, ".hold"}, 32'(hold_decode), 32'(hold));
        $display("[TB] %s v=%0b ld=%0b reg=%0d base=%0d off=%0d last=%0b hold=%0b",
                 tag, uop_valid, uop_is_load, uop_reg, uop_base, uop_offset, uop_last, hold_decode);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [3:0] op, input logic [7:0] m, input logic [2:0] b);
        valid_in = v;
        op_in    = op;
        imm8_in  = m;
        base_in  = b;
    endtask

    initial begin
        rst = 1'b1;
        present(1'b0, 4'h0, 8'h00, 3'd0);
        stall_in = 1'b0;
        flush_in = 1'b0;
        tick();
        tick();
        #2 expect_out("reset_held", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #2 expect_out("after_reset", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // LM A5, base 3; instruction held on valid_in while decode is frozen
        present(1'b1, LM, 8'b1010_0101, 3'd3);
        #2 expect_out("lm_a5.accept", 0, 0, 0, 0, 0, 0, 1);
        tick();
        #2 expect_out("lm_a5.u0", 1, 1, 0, 3, 0, 0, 1);
        tick();
        #2 expect_out("lm_a5.u1", 1, 1, 2, 3, 1, 0, 1);
        tick();
        #2 expect_out("lm_a5.u2", 1, 1, 5, 3, 2, 0, 1);
        tick();
        #2 expect_out("lm_a5.u3", 1, 1, 7, 3, 3, 1, 0);
        tick();
        present(1'b0, 4'h0, 8'h00, 3'd0);
        #2 expect_out("lm_a5.idle", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // SM FF, base 1, stall for two cycles on the third micro-op
        present(1'b1, SM, 8'hFF, 3'd1);
        #2 expect_out("sm_ff.accept", 0, 0, 0, 0, 0, 0, 1);
        tick();
        present(1'b0, 4'h0, 8'h00, 3'd0);
        #2 expect_out("sm_ff.u0", 1, 0, 0, 1, 0, 0, 1);
        tick();
        #2 expect_out("sm_ff.u1", 1, 0, 1, 1, 1, 0, 1);
        tick();
        stall_in = 1'b1;
        #2 expect_out("sm_ff.u2_stall0", 1, 0, 2, 1, 2, 0, 1);
        tick();
        #2 expect_out("sm_ff.u2_stall1", 1, 0, 2, 1, 2, 0, 1);
        tick();
        stall_in = 1'b0;
        #2 expect_out("sm_ff.u2_go", 1, 0, 2, 1, 2, 0, 1);
        tick();
        for (int i = 3; i < 8; i++) begin
            #2 expect_out($sformatf("sm_ff.u%0d", i), 1, 0, 3'(i), 1, DATA_W'(i),
                          (i == 7), (i != 7));
            tick();
        end
        #2 expect_out("sm_ff.idle", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // LM with an empty mask is a no-op
        present(1'b1, LM, 8'h00, 3'd4);
        #2 expect_out("lm_zero.present", 0, 0, 0, 0, 0, 0, 0);
        tick();
        present(1'b0, 4'h0, 8'h00, 3'd0);
        #2 expect_out("lm_zero.after", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // SM 0F, base 2, flushed on the second micro-op
        present(1'b1, SM, 8'h0F, 3'd2);
        #2 expect_out("sm_0f.accept", 0, 0, 0, 0, 0, 0, 1);
        tick();
        present(1'b0, 4'h0, 8'h00, 3'd0);
        #2 expect_out("sm_0f.u0", 1, 0, 0, 2, 0, 0, 1);
        tick();
        flush_in = 1'b1;
        #2 chk("sm_0f.flush.valid", 32'(uop_valid), 32'd0);
        chk("sm_0f.flush.hold", 32'(hold_decode), 32'd0);
        $display("[TB] sm_0f.flush v=%0b hold=%0b", uop_valid, hold_decode);
        tick();
        flush_in = 1'b0;
        #2 expect_out("sm_0f.idle0", 0, 0, 0, 0, 0, 0, 0);
        tick();
        #2 expect_out("sm_0f.idle1", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // LM F0, base 4, reset mid-sequence, then LM 01, base 5
        present(1'b1, LM, 8'hF0, 3'd4);
        #2 expect_out("lm_f0.accept", 0, 0, 0, 0, 0, 0, 1);
        tick();
        present(1'b0, 4'h0, 8'h00, 3'd0);
        #2 expect_out("lm_f0.u0", 1, 1, 4, 4, 0, 0, 1);
        tick();
        rst = 1'b1;
        #2 expect_out("lm_f0.rst", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        present(1'b1, LM, 8'h01, 3'd5);
        #2 expect_out("lm_01.accept", 0, 0, 0, 0, 0, 0, 1);
        tick();
        present(1'b0, 4'h0, 8'h00, 3'd0);
        #2 expect_out("lm_01.u0", 1, 1, 0, 5, 0, 1, 0);
        tick();
        #2 expect_out("lm_01.idle", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // LM 03, base 6, followed directly by SM 80, base 7
        present(1'b1, LM, 8'h03, 3'd6);
        #2 expect_out("b2b_lm.accept", 0, 0, 0, 0, 0, 0, 1);
        tick();
        #2 expect_out("b2b_lm.u0", 1, 1, 0, 6, 0, 0, 1);
        tick();
        #2 expect_out("b2b_lm.u1", 1, 1, 1, 6, 1, 1, 0);
        tick();
        present(1'b1, SM, 8'h80, 3'd7);
        #2 expect_out("b2b_sm.accept", 0, 0, 0, 0, 0, 0, 1);
        tick();
        present(1'b0, 4'h0, 8'h00, 3'd0);
        #2 expect_out("b2b_sm.u0", 1, 0, 7, 7, 0, 1, 0);
        tick();
        #2 expect_out("b2b_sm.idle", 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
